// File: rtl/dac_dual_buffer.sv
// Ping-pong DAC playback buffer. The MCU fills the inactive half over the FSMC-style bus,
// and the block plays the active half cyclically, swapping only at period boundaries.
module dac_dual_buffer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DAC_WIDTH  = 12,
    parameter int unsigned BUF_SIZE   = 1024,
    parameter logic [DATA_WIDTH-1:0] CTRL_ADDR = 16'h4000,
    parameter logic [DATA_WIDTH-1:0] LEN_ADDR  = 16'h4001
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  state,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  dac_tick,
    output logic [DAC_WIDTH-1:0]  dac_data,
    output logic                  dac_valid,
    output logic                  swap_pulse,
    output logic                  playing
);

    localparam int unsigned PW = $clog2(BUF_SIZE);
    localparam int unsigned MEM_DEPTH = 2 * BUF_SIZE;
    localparam logic [DAC_WIDTH-1:0] MIDSCALE = {1'b1, {(DAC_WIDTH-1){1'b0}}};
    localparam logic [PW-1:0] LEN_MAX = PW'(BUF_SIZE - 1);

    typedef enum logic [1:0] {B_IDLE, B_JUDGE, B_MCU_WR, B_MCU_RD} bus_state_t;
    typedef enum logic {P_IDLE, P_PLAY} play_state_t;

    bus_state_t            bstate;
    play_state_t           pstate;
    logic                  en_d;
    logic [DATA_WIDTH-1:0] addr;
    logic                  active_buf;
    logic                  pending;
    logic                  run;
    logic                  loaded;
    logic [PW-1:0]         active_len;
    logic [PW-1:0]         shadow_len;
    logic [PW-1:0]         rd_ptr;
    logic                  play_v1;
    logic [DAC_WIDTH-1:0]  rd_q;
    logic [DAC_WIDTH-1:0]  play_q;
    logic [DAC_WIDTH-1:0]  mem [MEM_DEPTH];

    logic                  wr_fire;
    logic                  ctrl_wr;
    logic                  len_wr;
    logic                  smp_wr;
    logic                  issue;
    logic                  wrap;
    logic                  do_swap;
    logic [DATA_WIDTH-1:0] rd_mux;

    // Bus write strobes: the write lands on the en falling edge with data on rd_data
    always_comb begin
        wr_fire = (bstate == B_MCU_WR) && !en;
        ctrl_wr = wr_fire && (addr == CTRL_ADDR);
        len_wr  = wr_fire && (addr == LEN_ADDR);
        smp_wr  = wr_fire && !addr[14];
    end

    always_comb begin
        rd_mux = '1;
        if (!addr[14]) begin
            rd_mux = DATA_WIDTH'(rd_q);
        end else if (addr == CTRL_ADDR) begin
            rd_mux = DATA_WIDTH'({active_buf, run, pending});
        end else if (addr == LEN_ADDR) begin
            rd_mux = DATA_WIDTH'(shadow_len);
        end
    end

    // Swap either immediately when idle, or at the wrap tick while playing
    always_comb begin
        issue   = (pstate == P_PLAY) && run && dac_tick;
        wrap    = (rd_ptr == active_len);
        do_swap = 1'b0;
        if (pstate == P_IDLE) begin
            do_swap = pending;
        end else if (issue && wrap) begin
            do_swap = pending;
        end
    end

    // Sample RAM; both buffers share one array indexed by {buffer, offset}
    always_ff @(posedge clk) begin
        if (smp_wr) begin
            mem[{~active_buf, addr[PW-1:0]}] <= rd_data[DAC_WIDTH-1:0];
        end
        rd_q   <= mem[{~active_buf, addr[PW-1:0]}];
        play_q <= mem[{active_buf, rd_ptr}];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bstate  <= B_IDLE;
            addr    <= '0;
            en_d    <= 1'b0;
            wr_data <= '0;
        end else begin
            en_d <= en;
            case (bstate)
                B_IDLE: begin
                    if (en && !en_d) begin
                        addr   <= rd_data;
                        bstate <= B_JUDGE;
                    end
                end
                B_JUDGE:  bstate <= state ? B_MCU_RD : B_MCU_WR;
                B_MCU_WR: begin
                    if (!en) bstate <= B_IDLE;
                end
                B_MCU_RD: begin
                    if (!en) bstate <= B_IDLE;
                    else     wr_data <= rd_mux;
                end
                default:  bstate <= B_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run        <= 1'b0;
            shadow_len <= LEN_MAX;
        end else begin
            if (ctrl_wr) run <= rd_data[1];
            if (len_wr)  shadow_len <= rd_data[PW-1:0];
        end
    end

    // Playback FSM, swap bookkeeping and the two-stage DAC pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pstate     <= P_IDLE;
            active_buf <= 1'b0;
            pending    <= 1'b0;
            loaded     <= 1'b0;
            active_len <= LEN_MAX;
            rd_ptr     <= '0;
            play_v1    <= 1'b0;
            dac_data   <= MIDSCALE;
            dac_valid  <= 1'b0;
            swap_pulse <= 1'b0;
            playing    <= 1'b0;
        end else begin
            swap_pulse <= do_swap;
            dac_valid  <= 1'b0;
            play_v1    <= issue;

            if (do_swap) begin
                active_buf <= ~active_buf;
                active_len <= len_wr ? rd_data[PW-1:0] : shadow_len;
                loaded     <= 1'b1;
                pending    <= 1'b0;
            end else if (ctrl_wr) begin
                pending <= rd_data[0];
            end

            case (pstate)
                P_IDLE: begin
                    if (run && loaded) begin
                        pstate  <= P_PLAY;
                        playing <= 1'b1;
                    end
                end
                P_PLAY: begin
                    if (!run) begin
                        pstate   <= P_IDLE;
                        playing  <= 1'b0;
                        rd_ptr   <= '0;
                        dac_data <= MIDSCALE;
                        play_v1  <= 1'b0;
                    end else begin
                        if (issue) rd_ptr <= wrap ? '0 : rd_ptr + PW'(1);
                        if (play_v1) begin
                            dac_data  <= play_q;
                            dac_valid <= 1'b1;
                        end
                    end
                end
                default: pstate <= P_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_dual_buffer.sv
// Directed bench for dac_dual_buffer: bus writes/reads, playback order, swap timing, reset.
module tb_dac_dual_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        state;
    logic [15:0] rd_data;
    logic [15:0] wr_data;
    logic        dac_tick;
    logic [11:0] dac_data;
    logic        dac_valid;
    logic        swap_pulse;
    logic        playing;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vcnt = 0;
    int scnt = 0;
    logic rec = 1'b0;
    logic [11:0] vq[$];
    int vcyc[$];
    logic [15:0] rdv;

    dac_dual_buffer dut (
        .clk(clk), .rst(rst), .en(en), .state(state), .rd_data(rd_data),
        .wr_data(wr_data), .dac_tick(dac_tick), .dac_data(dac_data),
        .dac_valid(dac_valid), .swap_pulse(swap_pulse), .playing(playing)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (dac_valid)  vcnt <= vcnt + 1;
        if (swap_pulse) scnt <= scnt + 1;
    end

    always @(negedge clk) begin
        if (rec && dac_valid) begin
            vq.push_back(dac_data);
            vcyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        rd_data = a; state = 1'b0; en = 1'b1;
        repeat (5) @(negedge clk);
        rd_data = d; en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        rd_data = a; state = 1'b1; en = 1'b1;
        repeat (6) @(negedge clk);
        d = wr_data;
        en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // One isolated tick; output must appear exactly two cycles later
    task automatic tick_chk(input logic [11:0] exp, input logic exp_swap);
        dac_tick = 1'b1;
        @(negedge clk);
        dac_tick = 1'b0;
        check("swap_at_tick", swap_pulse, exp_swap);
        check("valid_n1", dac_valid, 1'b0);
        @(negedge clk);
        check("valid_n2", dac_valid, 1'b1);
        check("dac_data", dac_data, exp);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int v0;
        int s0;
        logic [11:0] exp3 [8];
        exp3 = '{12'h201, 12'h100, 12'h101, 12'h102, 12'h103, 12'h100, 12'h101, 12'h102};
        rst = 1'b1; en = 1'b0; state = 1'b0; rd_data = '0; dac_tick = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_wr_data", wr_data, 16'h0000);
        check("rst_dac_data", dac_data, 12'h800);
        check("rst_valid", dac_valid, 1'b0);
        check("rst_swap", swap_pulse, 1'b0);
        check("rst_playing", playing, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        bus_read(16'h4001, rdv);
        check("rst_len", rdv, 16'h03FF);
        bus_read(16'h4000, rdv);
        check("rst_ctrl", rdv, 16'h0000);

        // Run without any commit: nothing plays
        bus_write(16'h4000, 16'h0002);
        repeat (3) @(negedge clk);
        v0 = vcnt;
        tick_chk_none();
        check("norun_playing", playing, 1'b0);
        check("norun_dac", dac_data, 12'h800);
        check("norun_valid_cnt", vcnt, v0);

        bus_write(16'h0005, 16'h0ABC);
        bus_read(16'h0005, rdv);
        check("smp_read", rdv, 16'h0ABC);
        bus_read(16'h4002, rdv);
        check("bad_addr_read", rdv, 16'hFFFF);

        // Basic playback of a 4-sample period
        do_reset();
        s0 = scnt;
        for (int i = 0; i < 4; i++) bus_write(16'(i), 16'h0100 + 16'(i));
        bus_write(16'h4001, 16'h0003);
        bus_write(16'h4000, 16'h0003);
        repeat (2) @(negedge clk);
        check("swap_cnt_1", scnt - s0, 1);
        check("playing_1", playing, 1'b1);
        tick_chk(12'h100, 1'b0);
        tick_chk(12'h101, 1'b0);
        tick_chk(12'h102, 1'b0);
        tick_chk(12'h103, 1'b0);
        tick_chk(12'h100, 1'b0);
        bus_read(16'h4000, rdv);
        check("ctrl_read_1", rdv, 16'h0006);

        // Commit mid-period: old period finishes, swap at wrap tick
        tick_chk(12'h101, 1'b0);
        bus_write(16'h0000, 16'h0200);
        bus_write(16'h0001, 16'h0201);
        bus_write(16'h4001, 16'h0001);
        bus_write(16'h4000, 16'h0003);
        bus_read(16'h4000, rdv);
        check("ctrl_pending", rdv, 16'h0007);
        s0 = scnt;
        tick_chk(12'h102, 1'b0);
        tick_chk(12'h103, 1'b1);
        tick_chk(12'h200, 1'b0);
        tick_chk(12'h201, 1'b0);
        tick_chk(12'h200, 1'b0);
        check("swap_cnt_2", scnt - s0, 1);
        bus_read(16'h4000, rdv);
        check("ctrl_read_2", rdv, 16'h0002);

        // Back-to-back ticks across a swap into the 4-sample buffer
        bus_write(16'h4001, 16'h0003);
        bus_write(16'h4000, 16'h0003);
        s0 = scnt;
        vq.delete(); vcyc.delete();
        rec = 1'b1;
        repeat (8) begin
            dac_tick = 1'b1;
            @(negedge clk);
        end
        dac_tick = 1'b0;
        repeat (4) @(negedge clk);
        rec = 1'b0;
        check("b2b_count", vq.size(), 8);
        if (vq.size() == 8) begin
            for (int i = 0; i < 8; i++) check($sformatf("b2b_data%0d", i), vq[i], exp3[i]);
            check("b2b_consecutive", vcyc[7] - vcyc[0], 7);
        end
        check("swap_cnt_3", scnt - s0, 1);

        // Reset in the middle of playback with a tick in flight
        bus_write(16'h4000, 16'h0003);
        bus_read(16'h4000, rdv);
        check("ctrl_pending_2", rdv, 16'h0007);
        v0 = vcnt;
        dac_tick = 1'b1;
        @(negedge clk);
        dac_tick = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_dac", dac_data, 12'h800);
        check("mid_rst_playing", playing, 1'b0);
        check("mid_rst_valid", dac_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_valid_cnt", vcnt, v0);
        bus_read(16'h4000, rdv);
        check("mid_rst_ctrl", rdv, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Tick while not playing: no output pulse may follow
    task automatic tick_chk_none();
        dac_tick = 1'b1;
        @(negedge clk);
        dac_tick = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_tick_valid", dac_valid, 1'b0);
        @(negedge clk);
    endtask

endmodule

// File: doc/dac_dual_buffer.md
Name: dac_dual_buffer

Overview:
- Ping-pong playback buffer feeding a parallel DAC; the output-side counterpart of the ADC capture buffer.
- MCU fills the inactive buffer over the FSMC-style bus (en / state / rd_data / wr_data), sets the period length and commits.
- Block plays the active buffer cyclically on each dac_tick and swaps buffers only at a period boundary, so the waveform never glitches.

Parameters:
- DATA_WIDTH, 16, bus data/address width
- DAC_WIDTH, 12, DAC sample width; bus writes use the low DAC_WIDTH bits
- BUF_SIZE, 1024, samples per buffer (power of 2); PW = $clog2(BUF_SIZE)
- CTRL_ADDR, 16'h4000, control/status register
- LEN_ADDR, 16'h4001, shadow period-length register

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- en  in  1  bus enable, synchronous to clk; rising edge starts an access
- state  in  1  access type: 0 = MCU writes to block, 1 = MCU reads from block
- rd_data  in  DATA_WIDTH  bus input: address at en rise, write data at en fall
- wr_data  out  DATA_WIDTH  read data returned to MCU
- dac_tick  in  1  one-cycle sample strobe, any spacing including back-to-back
- dac_data  out  DAC_WIDTH  sample to DAC
- dac_valid  out  1  one-cycle pulse when dac_data updates
- swap_pulse  out  1  one-cycle pulse when the active buffer changes
- playing  out  1  high in PLAY

Behaviour:
- Reset values:
  - Outputs: wr_data=0, dac_data=12'h800 (midscale), dac_valid=0, swap_pulse=0, playing=0.
  - Internal: active_buf=0, pending=0, run=0, loaded=0, active_len=shadow_len=BUF_SIZE-1, rd_ptr=0, FSMs in idle.
  - RAM contents are not cleared.
- Bus FSM (B_IDLE, B_JUDGE, B_MCU_WR, B_MCU_RD):
  - en rise: latch addr=rd_data, go to B_JUDGE.
  - B_JUDGE: next state is B_MCU_RD if state=1, else B_MCU_WR.
- B_MCU_WR, on en fall (captures rd_data, then returns to B_IDLE):
  - addr[14]=0: write rd_data[DAC_WIDTH-1:0] to inactive buffer at addr[PW-1:0].
  - CTRL_ADDR: bit1 sets run. Bit0=1 sets pending; bit0=0 clears pending if the swap has not yet been taken.
  - LEN_ADDR: shadow_len = rd_data[PW-1:0].
  - Other control addresses are ignored.
- B_MCU_RD: wr_data is updated every cycle while en is high; return to B_IDLE when en is low.
  - CTRL_ADDR returns {13'b0, active_buf, run, pending}.
  - LEN_ADDR returns {0, shadow_len}.
  - Sample space returns {0, inactive RAM[addr]} with 2-cycle RAM+register latency.
  - Other control addresses return 16'hFFFF.
  - The MCU holds en high for at least 5 clk cycles.
- Playback FSM (P_IDLE, P_PLAY):
  - P_IDLE with pending=1: immediate swap (active_buf toggles, active_len=shadow_len, pending=0, loaded=1, swap_pulse).
  - P_IDLE to P_PLAY when run=1 and loaded=1.
  - P_PLAY, on dac_tick: RAM address = rd_ptr of active_buf.
    - If rd_ptr==active_len: rd_ptr=0; if pending, swap in that same cycle.
    - Otherwise rd_ptr+1.
  - P_PLAY to P_IDLE the cycle after run=0: rd_ptr=0, dac_data returns to 12'h800. Ticks in flight are dropped.
- DAC pipeline:
  - Tick at cycle N: dac_data and dac_valid appear at N+2.
  - Buffer select is pipelined with the address, so the sample at the wrap is taken from the old buffer.
  - The sample after the wrap is taken from the new buffer.
- Simultaneous events:
  - Sample write in the same cycle as a swap targets the buffer inactive before the swap.
  - Commit while pending=1: no effect.
  - LEN write after commit but before the swap is taken: the new value is used.
- Reset mid-operation returns everything to reset values at once.

Test Plan:
- Write 0..3 to inactive buffer as 12'h100..12'h103, LEN=3, CTRL=3, then ticks every 4 cycles -> dac_data 100,101,102,103,100… each 2 cycles after its tick; one swap_pulse before the first tick; CTRL readback=0x0006.
- Fill other buffer with 12'h200..12'h201, LEN=1, commit mid-period -> old period completes (…102,103), then 200,201,200; swap_pulse on the wrap tick cycle; pending reads 0 afterwards.
- Back-to-back dac_tick for 8 cycles with LEN=3 -> dac_valid high 8 consecutive cycles, sequence wraps correctly.
- Write CTRL=2 (run, no commit) after reset -> playing stays 0, dac_data=12'h800.
- Read sample address 5 after writing 12'hABC there -> wr_data=16'h0ABC while en held; read 0x4002 -> 16'hFFFF.
- Assert rst during PLAY -> next cycle dac_data=12'h800, playing=0, pending=0, no dac_valid.
